interface_hcsr04_medidor: RTL and testbench

//  Ultrasonic front end of the digital tape measure. On a medir pulse from the control unit it fires a
//  HC-SR04 trigger pulse and times the returned echo. It converts the echo width to centimetres as
//  3 BCD digits and pulses pronto, which drives the control unit's fim_medida input.
//  The BCD digits are the characters the transmit path sends out.

---
 rtl/interface_hcsr04_medidor.sv | 199 +++++++++++++++++++
 tb/tb_interface_hcsr04_medidor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interface_hcsr04_medidor.sv
// HC-SR04 ultrasonic front end: fires the trigger pulse, times the echo and
// converts its width to a 3-digit BCD distance in centimetres.
module interface_hcsr04_medidor #(
  parameter int unsigned TRIGGER_CYCLES = 500,
  parameter int unsigned CM_CYCLES      = 2941,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned TRIG_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
  localparam int unsigned TICK_W = (CM_CYCLES > 1)      ? $clog2(CM_CYCLES)      : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TRIG_W-1:0] TRIG_LAST   = TRIG_W'(TRIGGER_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(CM_CYCLES - 1);
  // Half a centimetre of preload turns the truncating count into round-to-nearest
  localparam logic [TICK_W-1:0] TICK_PRESET = TICK_W'(CM_CYCLES / 2);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    st_inicial     = 4'd0,
    st_dispara     = 4'd1,
    st_espera_echo = 4'd2,
    st_mede        = 4'd3,
    st_armazena    = 4'd4,
    st_final       = 4'd5,
    st_erro_to     = 4'd6
  } estado_t;

  estado_t estado;
  estado_t proximo;

  logic              echo_meta;
  logic              echo_s;
  logic              inicia;
  logic [TRIG_W-1:0] trig_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [3:0]        bcd_c;
  logic [3:0]        bcd_d;
  logic [3:0]        bcd_u;
  logic [11:0]       bcd;
  logic              trig_fim;
  logic              tick_fim;
  logic              to_fim;
  logic              bcd_sat;

  assign bcd       = {bcd_c, bcd_d, bcd_u};
  assign trig_fim  = (trig_cnt == TRIG_LAST);
  assign tick_fim  = (tick_cnt == TICK_LAST);
  assign to_fim    = (to_cnt == TO_LAST);
  assign bcd_sat   = (bcd == 12'h999);
  assign db_estado = estado;

  // Two-flop synchroniser for the asynchronous echo input
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= st_inicial;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic; echo edges take priority over a coincident timeout
  always_comb begin
    proximo = estado;
    inicia  = 1'b0;
    case (estado)
      st_inicial, st_final: begin
        if (medir) begin
          proximo = st_dispara;
          inicia  = 1'b1;
        end
      end
      st_dispara: begin
        if (trig_fim) begin
          proximo = st_espera_echo;
        end
      end
      st_espera_echo: begin
        if (echo_s) begin
          proximo = st_mede;
        end else if (to_fim) begin
          proximo = st_erro_to;
        end
      end
      st_mede: begin
        if (!echo_s) begin
          proximo = st_armazena;
        end else if (to_fim) begin
          proximo = st_erro_to;
        end
      end
      st_armazena: proximo = st_final;
      st_erro_to:  proximo = st_final;
      default:     proximo = st_inicial;
    endcase
  end

  // Trigger-width counter, cleared whenever a measurement is accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_cnt <= '0;
    end else if (inicia) begin
      trig_cnt <= '0;
    end else if (estado == st_dispara && proximo == st_dispara) begin
      trig_cnt <= trig_cnt + TRIG_W'(1);
    end
  end

  // Timeout counter, restarted on every state change (entry to espera_echo / mede)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (proximo != estado) begin
      to_cnt <= '0;
    end else if (estado == st_espera_echo || estado == st_mede) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Sub-centimetre tick counter, preloaded at echo start for rounding
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (estado == st_espera_echo && proximo == st_mede) begin
      tick_cnt <= TICK_PRESET;
    end else if (estado == st_mede) begin
      tick_cnt <= tick_fim ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  // Saturating three-digit BCD centimetre counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_c <= '0;
      bcd_d <= '0;
      bcd_u <= '0;
    end else if (inicia) begin
      bcd_c <= '0;
      bcd_d <= '0;
      bcd_u <= '0;
    end else if (estado == st_mede && tick_fim && !bcd_sat) begin
      if (bcd_u == 4'd9) begin
        bcd_u <= '0;
        if (bcd_d == 4'd9) begin
          bcd_d <= '0;
          bcd_c <= bcd_c + 4'd1;
        end else begin
          bcd_d <= bcd_d + 4'd1;
        end
      end else begin
        bcd_u <= bcd_u + 4'd1;
      end
    end
  end

  // Registered outputs; pronto fires once, on entry to final or erro_to
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trigger <= 1'b0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
      medida  <= 12'h000;
    end else begin
      trigger <= (proximo == st_dispara);
      pronto  <= (estado == st_armazena) || (proximo == st_erro_to);
      if (inicia) begin
        erro <= 1'b0;
      end else if (proximo == st_erro_to) begin
        erro <= 1'b1;
      end
      if (estado == st_armazena) begin
        medida <= bcd;
      end
    end
  end

endmodule

// File: tb/tb_interface_hcsr04_medidor.sv
// Scoreboard bench for interface_hcsr04_medidor, run with scaled-down timing.
module tb_interface_hcsr04_medidor;

  localparam int unsigned TRIG = 50;
  localparam int unsigned CM   = 7;
  localparam int unsigned TO   = 8000;

  logic        clock;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  typedef struct {
    logic [11:0] med;
    logic        err;
    int          ref_cyc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pushed = 0;
  int          pronto_cnt = 0;
  int          cyc = 0;
  logic        prev_pronto = 1'b0;
  logic [11:0] last_med = 12'h000;

  interface_hcsr04_medidor #(
    .TRIGGER_CYCLES(TRIG),
    .CM_CYCLES(CM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .medir(medir),
    .echo(echo),
    .trigger(trigger),
    .medida(medida),
    .pronto(pronto),
    .erro(erro),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  // Monitor: every pronto pulse is matched against the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && pronto) begin
        pronto_cnt++;
        check("pronto_width", 32'(prev_pronto), 32'd0);
        if (exp_q.size() == 0) begin
          check("pronto_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("medida", 32'(medida), 32'(e.med));
          check("erro", 32'(erro), 32'(e.err));
          check("latency", 32'(cyc - e.ref_cyc), 32'(e.lat));
        end
      end
      prev_pronto = pronto;
    end
  end

  task automatic push_exp(input logic [11:0] med, input logic err, input int ref_cyc, input int lat);
    exp_t e;
    e.med = med;
    e.err = err;
    e.ref_cyc = ref_cyc;
    e.lat = lat;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic start_pulse();
    @(posedge clock); #1 medir = 1'b1;
    @(posedge clock); #1 medir = 1'b0;
  endtask

  // Waits for the trigger pulse, checks its width and returns the espera_echo entry cycle
  task automatic count_trigger(output int esp_cyc);
    int hi = 0;
    bit done = 0;
    esp_cyc = cyc;
    for (int i = 0; i < int'(TRIG) + 200 && !done; i++) begin
      @(negedge clock);
      if (trigger) begin
        if (hi == 0) begin
          check("estado_dispara", 32'(db_estado), 32'd1);
          check("erro_cleared", 32'(erro), 32'd0);
        end
        hi++;
      end else if (hi > 0) begin
        done = 1;
        esp_cyc = cyc;
        check("estado_espera", 32'(db_estado), 32'd2);
      end
    end
    check("trigger_width", 32'(hi), 32'(TRIG));
  endtask

  task automatic apply_echo(input int n, input int medir_at, input logic [11:0] med);
    @(posedge clock); #1 echo = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (medir_at >= 0) medir = (i == medir_at);
    end
    echo = 1'b0;
    push_exp(med, 1'b0, cyc, 4);
    last_med = med;
  endtask

  task automatic wait_pronto(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (pronto) seen = 1;
    end
    if (!seen) check("pronto_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure(input int n, input logic [11:0] med, input int medir_at);
    int esp;
    start_pulse();
    count_trigger(esp);
    apply_echo(n, medir_at, med);
    wait_pronto(50);
    repeat (3) @(negedge clock);
  endtask

  typedef struct {
    int          n;
    logic [11:0] med;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   esp;
    bit   found;
    vecs = '{'{70, 12'h010}, '{3, 12'h000}, '{4, 12'h001}, '{690, 12'h099},
             '{700, 12'h100}, '{1, 12'h000}, '{18, 12'h003}};

    reset = 1'b1;
    medir = 1'b0;
    echo  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_medida", 32'(medida), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b0;

    // Reset asserted in the middle of the trigger pulse
    start_pulse();
    repeat (20) @(negedge clock);
    check("mid_trigger_high", 32'(trigger), 32'd1);
    check("mid_estado", 32'(db_estado), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_trigger", 32'(trigger), 32'd0);
    check("abort_estado", 32'(db_estado), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Normal, rounding and BCD-carry measurements
    foreach (vecs[k]) measure(vecs[k].n, vecs[k].med, -1);

    // No echo at all: timeout counted from espera_echo entry
    start_pulse();
    count_trigger(esp);
    push_exp(last_med, 1'b1, esp, int'(TO));
    wait_pronto(int'(TO) + 50);
    repeat (3) @(negedge clock);
    check("erro_held", 32'(erro), 32'd1);

    // Next accepted medir clears erro
    measure(35, 12'h005, -1);

    // Echo stuck high: timeout counted from mede entry
    start_pulse();
    count_trigger(esp);
    @(posedge clock); #1 echo = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (db_estado == 4'd3) found = 1;
    end
    check("enter_mede", 32'(found), 32'd1);
    push_exp(last_med, 1'b1, cyc, int'(TO));
    wait_pronto(int'(TO) + 50);
    echo = 1'b0;
    repeat (10) @(negedge clock);
    check("erro_stuck_held", 32'(erro), 32'd1);
    check("estado_final", 32'(db_estado), 32'd5);

    // Saturation at 999
    measure(7200, 12'h999, -1);

    // medir pulsed during mede is ignored
    measure(140, 12'h020, 20);

    // medir held high: back-to-back measurements
    @(posedge clock); #1 medir = 1'b1;
    count_trigger(esp);
    apply_echo(14, -1, 12'h002);
    wait_pronto(50);
    count_trigger(esp);
    apply_echo(49, -1, 12'h007);
    wait_pronto(50);
    medir = 1'b0;
    repeat (20) @(negedge clock);
    check("held_idle_trigger", 32'(trigger), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("pronto_count", 32'(pronto_cnt), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
